ect_switch_sequencer: RTL
=========================

Name: ect_switch_sequencer

Overview:
Parametrised electrode-switch sequencer for the ECT front end. It latches a scan mode on Start and steps through every excitation/detection electrode pair of an N-electrode sensor. For each pair it drives the 2-bit-per-electrode switch word, waits a settle time, handshakes one measurement with the demodulator, then advances. It sits between the command decoder and the analogue switch array and generates patterns itself instead of selecting precomputed words.

Parameters:
N_ELEC, 12, electrode count; even, 4..16.
SETTLE_CYC, 16, Clk cycles between a pattern change and MeasReq; 0 allowed.
TIMEOUT_CYC, 65535, maximum Clk cycles in MEAS waiting for MeasDone; 16-bit counter.

Ports:
Clk  in  1  system clock
Clr  in  1  asynchronous active-high reset
Start  in  1  begin scan; sampled only in IDLE
Mode  in  2  00 single scan, 01 twin scan, 10 single fixed pair 1-2, 11 twin fixed pairs 1-2 and H+1-H+2
Abort  in  1  stop scan, return to GND
MeasDone  in  1  demodulator finished current measurement
SwitchData  out  2*N_ELEC  per-electrode code, electrode k at bits [2k+1:2k]
MeasReq  out  1  measurement request, level
MeasIdx  out  8  index of current measurement, 0-based
MeasNum  out  8  total measurements for the latched mode
Busy  out  1  scan in progress
Done  out  1  one-cycle pulse after the last measurement
Error  out  1  sticky timeout flag
Ch1En  out  1  demod channel 1 enable
Ch2En  out  1  demod channel 2 enable

Behaviour:
- Clock and reset: one clock (Clk); Clr is asynchronous and active-high.
- Electrode codes: EXC = 11, MEAS = 00, GND = 10.
- Reset values: SwitchData all GND (N_ELEC=8 gives 16'hAAAA); all other outputs 0; state IDLE.
- Mode latched at Start. Define L = N_ELEC for single modes and H = N_ELEC/2 for twin modes.
- MeasNum: single L(L-1)/2; twin H(H-1)/2; fixed modes 1. Valid from the cycle after Start until the next Start.
- Ch1En = 1 in all modes; Ch2En = 1 in twin modes only. Both are held until the next Start.
- Pair order: (i, j) with i < j < L. j increments first; when j = L-1, i increments and j = i+1. Last pair is (L-2, L-1).
- Pattern: electrode i = EXC, electrode j = MEAS, all others GND. Twin modes also drive i+H = EXC and j+H = MEAS. Fixed modes use the pair (0,1) only.
- FSM states IDLE, SETTLE, MEAS, DONE.
  - IDLE -> SETTLE on Start: i=0, j=1, MeasIdx=0, Busy=1, Error cleared.
  - SETTLE: the pattern for the current pair is registered on the cycle of entry and held for SETTLE_CYC cycles. If SETTLE_CYC = 0, MEAS is entered on the next cycle.
  - MEAS: MeasReq = 1 until MeasDone is sampled high. In that same cycle MeasReq falls next edge; if MeasIdx = MeasNum-1 go to DONE, else advance the pair, MeasIdx+1, return to SETTLE.
  - DONE: one cycle with Done = 1, SwitchData = GND, Busy = 0, then IDLE.
- MeasDone outside MEAS is ignored.
- Start while Busy is ignored.
- Abort: from any state, IDLE next cycle. SwitchData = GND, MeasReq = 0, Busy = 0, no Done. Abort wins over a simultaneous MeasDone or Start.
- Timeout: MEAS counter reaches TIMEOUT_CYC with no MeasDone -> Error = 1 (sticky), then treated as Abort.
- Clr mid-scan: immediate return to reset values.
- MeasIdx is 8 bits. Maximum MeasNum is 120 (N_ELEC=16), so it never wraps.

Decomposition:
- Package ect_sw_pkg:
  - electrode codes EXC/MEAS/GND;
  - Mode encodings;
  - FSM state enum;
  - function meas_count(L).
- One sub-module, ect_pair_pattern: combinational (i, j, twin) -> SwitchData encoder, parametrised by N_ELEC. The sequencer registers its output.

Test Plan:
All scenarios use N_ELEC=8, SETTLE_CYC=2.
- Reset: assert Clr -> SwitchData=16'hAAAA; Busy, MeasReq, Done, Error, Ch1En, Ch2En = 0.
- Single scan (Mode=00), Start, MeasDone 1 cycle after each MeasReq -> MeasNum=28; patterns 16'hAAA3, 16'hAA8B, ... last 16'h3AAA; MeasReq rises 2 cycles after each pattern change; Done pulses once after the 28th MeasDone; Ch2En=0.
- Twin scan (Mode=01) -> MeasNum=6, first pattern 16'hA3A3, Ch1En=Ch2En=1, Done after 6 handshakes.
- Fixed single (Mode=10) -> MeasNum=1, pattern 16'hAAA3, Done after one MeasDone.
- Abort asserted in MEAS at MeasIdx=5, same cycle as MeasDone -> next cycle SwitchData=16'hAAAA, Busy=0, no Done; a following Start restarts at MeasIdx=0.
- TIMEOUT_CYC=10, MeasDone held low -> Error=1 after 10 cycles in MEAS, state IDLE, SwitchData=GND; the next Start clears Error.

Source files
------------

// File: rtl/ect_sw_pkg.sv
// Shared encodings for the ECT electrode-switch sequencer: electrode codes,
// scan modes, FSM states and the pair-count helper.
package ect_sw_pkg;

  localparam logic [1:0] EL_EXC  = 2'b11;
  localparam logic [1:0] EL_MEAS = 2'b00;
  localparam logic [1:0] EL_GND  = 2'b10;

  typedef enum logic [1:0] {
    MODE_SINGLE     = 2'b00,
    MODE_TWIN       = 2'b01,
    MODE_FIX_SINGLE = 2'b10,
    MODE_FIX_TWIN   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_DONE
  } state_e;

  // Number of unordered electrode pairs among l electrodes.
  function automatic logic [7:0] meas_count(input logic [7:0] l);
    logic [15:0] p;
    p = {8'd0, l} * {8'd0, l - 8'd1};
    return 8'(p >> 1);
  endfunction

endpackage

// File: rtl/ect_pair_pattern.sv
// Combinational encoder: excitation/detection pair (and optional twin copy
// offset by half the ring) to the per-electrode switch word.
module ect_pair_pattern
  import ect_sw_pkg::*;
#(
  parameter int N_ELEC = 12
) (
  input  logic [7:0]          i_i,
  input  logic [7:0]          j_i,
  input  logic                twin_i,
  output logic [2*N_ELEC-1:0] sw_o
);

  localparam logic [7:0] HALF = 8'(N_ELEC / 2);

  always_comb begin
    sw_o = '0;
    for (int k = 0; k < N_ELEC; k++) begin
      sw_o[2*k +: 2] = EL_GND;
      if (8'(k) == i_i || (twin_i && 8'(k) == i_i + HALF))
        sw_o[2*k +: 2] = EL_EXC;
      if (8'(k) == j_i || (twin_i && 8'(k) == j_i + HALF))
        sw_o[2*k +: 2] = EL_MEAS;
    end
  end

endmodule

// File: rtl/ect_switch_sequencer.sv
// Electrode-switch sequencer: walks every excitation/detection pair, settles,
// handshakes one demodulator measurement per pair, with abort and timeout.
module ect_switch_sequencer
  import ect_sw_pkg::*;
#(
  parameter int N_ELEC      = 12,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic                Start,
  input  logic [1:0]          Mode,
  input  logic                Abort,
  input  logic                MeasDone,
  output logic [2*N_ELEC-1:0] SwitchData,
  output logic                MeasReq,
  output logic [7:0]          MeasIdx,
  output logic [7:0]          MeasNum,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic                Ch1En,
  output logic                Ch2En
);

  localparam logic [2*N_ELEC-1:0] GND_WORD = {N_ELEC{EL_GND}};
  // Settle of 0 or 1 both leave SETTLE after the entry cycle.
  localparam logic [15:0] SETTLE_LAST = (SETTLE_CYC > 1) ? 16'(SETTLE_CYC - 1) : 16'd0;
  localparam logic [15:0] TMO_LAST    = (TIMEOUT_CYC > 1) ? 16'(TIMEOUT_CYC - 1) : 16'd0;

  state_e              state_q;
  logic [7:0]          i_q, j_q, i_d, j_d, lim_q;
  logic                twin_q;
  logic [15:0]         cnt_q;
  logic [2*N_ELEC-1:0] sw_q, pat_word;
  logic [7:0]          idx_q, num_q, pat_i, pat_j;
  logic                req_q, busy_q, done_q, err_q, ch1_q, ch2_q, pat_twin;
  logic                tmo_hit;

  always_comb begin
    if (j_q == lim_q - 8'd1) begin
      i_d = i_q + 8'd1;
      j_d = i_q + 8'd2;
    end else begin
      i_d = i_q;
      j_d = j_q + 8'd1;
    end
    // In IDLE the encoder previews the first pair so it can load on Start.
    if (state_q == ST_IDLE) begin
      pat_i    = 8'd0;
      pat_j    = 8'd1;
      pat_twin = Mode[0];
    end else begin
      pat_i    = i_d;
      pat_j    = j_d;
      pat_twin = twin_q;
    end
  end

  assign tmo_hit = (state_q == ST_MEAS) && !MeasDone && (cnt_q == TMO_LAST);

  ect_pair_pattern #(.N_ELEC(N_ELEC)) u_pattern (
    .i_i    (pat_i),
    .j_i    (pat_j),
    .twin_i (pat_twin),
    .sw_o   (pat_word)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd1;
      lim_q   <= 8'(N_ELEC);
      twin_q  <= 1'b0;
      cnt_q   <= 16'd0;
      sw_q    <= GND_WORD;
      idx_q   <= 8'd0;
      num_q   <= 8'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ch1_q   <= 1'b0;
      ch2_q   <= 1'b0;
    end else if (Abort || tmo_hit) begin
      state_q <= ST_IDLE;
      sw_q    <= GND_WORD;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
      err_q   <= err_q | tmo_hit;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q <= ST_SETTLE;
            i_q     <= 8'd0;
            j_q     <= 8'd1;
            lim_q   <= Mode[0] ? 8'(N_ELEC / 2) : 8'(N_ELEC);
            twin_q  <= Mode[0];
            num_q   <= Mode[1] ? 8'd1 : meas_count(Mode[0] ? 8'(N_ELEC / 2) : 8'(N_ELEC));
            ch1_q   <= 1'b1;
            ch2_q   <= Mode[0];
            sw_q    <= pat_word;
            idx_q   <= 8'd0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= ST_MEAS;
            req_q   <= 1'b1;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_MEAS: begin
          if (MeasDone) begin
            req_q <= 1'b0;
            cnt_q <= 16'd0;
            if (idx_q == num_q - 8'd1) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              sw_q    <= GND_WORD;
            end else begin
              state_q <= ST_SETTLE;
              i_q     <= i_d;
              j_q     <= j_d;
              idx_q   <= idx_q + 8'd1;
              sw_q    <= pat_word;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign SwitchData = sw_q;
  assign MeasReq    = req_q;
  assign MeasIdx    = idx_q;
  assign MeasNum    = num_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Error      = err_q;
  assign Ch1En      = ch1_q;
  assign Ch2En      = ch2_q;

endmodule
